// File: rtl/lab_f_sar_search_pkg.sv
// Shared definitions for the Lab F binary-search controller.
//   SAR_WIDTH   : default operand width (search space 0..2^SAR_WIDTH-1)
//   sar_state_e : controller states (1-bit encoding)
package lab_f_sar_search_pkg;

  localparam int unsigned SAR_WIDTH = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_PROBE = 1'b1
  } sar_state_e;

endpackage

// File: rtl/lab_f_sar_search.sv
// Sequential binary-search controller that drives the B operand of the Lab F
// magnitude comparator and narrows a [lo,hi] window from its G/E/L answer
// until the hidden A operand is located.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   start    : request a new search (sampled only in IDLE)
//   G, E, L  : comparator outputs for A vs. guess
//   guess    : registered probe value driven to comparator B
//   busy     : high while probing
//   done     : one-cycle pulse when a search ends (found or error)
//   found    : result valid, held until the next accepted start
//   result   : located value, held until the next accepted start
//   error    : comparator answer was inconsistent, held until next start
module lab_f_sar_search
  import lab_f_sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             G,
  input  logic             E,
  input  logic             L,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam logic [WIDTH-1:0] MAX_VAL   = '1;
  localparam logic [WIDTH-1:0] FIRST_MID = MAX_VAL >> 1;

  sar_state_e       state, state_n;
  logic [WIDTH-1:0] lo, lo_n, hi, hi_n;
  logic [WIDTH-1:0] guess_n, result_n;
  logic             busy_n, done_n, found_n, error_n;

  // Midpoint sums are one bit wider so lo+hi near the top does not wrap.
  logic [WIDTH:0]   sum_up, sum_dn;
  logic [WIDTH-1:0] mid_up, mid_dn;
  logic             fail;

  assign sum_up = {1'b0, guess} + {1'b0, hi} + (WIDTH+1)'(1);
  assign sum_dn = {1'b0, lo} + {1'b0, guess} - (WIDTH+1)'(1);
  assign mid_up = WIDTH'(sum_up >> 1);
  assign mid_dn = WIDTH'(sum_dn >> 1);

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    result_n = result;
    busy_n   = busy;
    done_n   = 1'b0;
    found_n  = found;
    error_n  = error;
    fail     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = MAX_VAL;
          guess_n  = FIRST_MID;
          result_n = '0;
          found_n  = 1'b0;
          error_n  = 1'b0;
          busy_n   = 1'b1;
          state_n  = S_PROBE;
        end
      end
      S_PROBE: begin
        unique case ({G, E, L})
          3'b010: begin
            result_n = guess;
            found_n  = 1'b1;
            done_n   = 1'b1;
            busy_n   = 1'b0;
            state_n  = S_IDLE;
          end
          // Edge guards keep guess+1 / guess-1 inside the operand range.
          3'b100: begin
            if (guess == hi) begin
              fail = 1'b1;
            end else begin
              lo_n    = guess + WIDTH'(1);
              guess_n = mid_up;
            end
          end
          3'b001: begin
            if (guess == lo) begin
              fail = 1'b1;
            end else begin
              hi_n    = guess - WIDTH'(1);
              guess_n = mid_dn;
            end
          end
          default: fail = 1'b1;
        endcase

        if (fail) begin
          error_n = 1'b1;
          found_n = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      lo     <= '0;
      hi     <= MAX_VAL;
      guess  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
      found  <= found_n;
      error  <= error_n;
    end
  end

endmodule
